// File: rtl/button_debounce_pkg.sv
// Shared types and defaults for the push-button debouncer and its synchronizer.
package button_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_250_000;
    localparam int unsigned DEF_LONG_CYCLES     = 125_000_000;
    localparam int          PRESS_CNT_W         = 8;

endpackage

// File: rtl/button_debounce_sync.sv
// Two-flop synchronizer for an asynchronous pin; reset loads RST_VAL (the pin's idle level).
module btn_sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;

    always_comb begin
        sync1_d = d;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= RST_VAL;
            sync2_q <= RST_VAL;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign q = sync2_q;

endmodule

// File: rtl/button_debounce.sv
// Push-button synchronizer + debouncer with press/release strobes and a wrapping press count.
// Long-press detection is compiled in with `define BUTTON_DEBOUNCE_LONG_PRESS_EN.
module button_debounce
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int          CNT_W           = 21,
    parameter bit          ACTIVE_LOW      = 1'b0,
    parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int          LONG_W          = 27
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   btn_raw,
    output logic                   btn_level,
    output logic                   press_pulse,
    output logic                   release_pulse,
    output logic [PRESS_CNT_W-1:0] press_count,
    output logic                   long_pulse
);

    if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2 ||
        (64'd1 << CNT_W) < 64'(DEBOUNCE_CYCLES) ||
        (64'd1 << LONG_W) < 64'(LONG_CYCLES)) begin : g_bad_cfg
        $error("button_debounce: illegal parameter combination");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic btn_sync, btn_s;

    btn_sync_2ff #(
        .RST_VAL (ACTIVE_LOW)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_raw),
        .q   (btn_sync)
    );

    // Polarity is normalised after the synchronizer so btn_s = 1 always means pressed.
    assign btn_s = btn_sync ^ ACTIVE_LOW;

    btn_state_t             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic [PRESS_CNT_W-1:0] count_q, count_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        count_d   = count_q;
        case (state_q)
            RELEASED: begin
                if (btn_s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                    count_d = count_q + PRESS_CNT_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                // A return to pressed here is a release bounce: no strobe, no count.
                if (btn_s) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = RELEASED;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RELEASED;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            count_q   <= count_d;
        end
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign press_count   = count_q;

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    localparam logic [LONG_W-1:0] HCNT_LAST = LONG_W'(LONG_CYCLES - 1);

    logic [LONG_W-1:0] hcnt_q, hcnt_d;
    logic              done_q, done_d;
    logic              long_q, long_d;

    // Hold time is measured from the accepted press; done_q limits it to one strobe per press.
    always_comb begin
        hcnt_d = hcnt_q;
        done_d = done_q;
        long_d = 1'b0;
        if (press_d) begin
            hcnt_d = '0;
            done_d = 1'b0;
        end else if ((state_q == PRESSED || state_q == RELEASE_WAIT) && !done_q) begin
            if (hcnt_q == HCNT_LAST) begin
                long_d = 1'b1;
                done_d = 1'b1;
            end else begin
                hcnt_d = hcnt_q + LONG_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt_q <= '0;
            done_q <= 1'b0;
            long_q <= 1'b0;
        end else begin
            hcnt_q <= hcnt_d;
            done_q <= done_d;
            long_q <= long_d;
        end
    end

    assign long_pulse = long_q;
`else
    assign long_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce: an active-high and an active-low instance see the same button.
module tb_button_debounce;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn = 1'b0;
    logic       btn_n;
    logic [1:0] lvl, pp, rp, lp;
    logic [7:0] pc0, pc1;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    int npress [2] = '{0, 0};
    int nrel   [2] = '{0, 0};
    int nlong  [2] = '{0, 0};
    int tpress [2] = '{0, 0};
    int trel   [2] = '{0, 0};
    int tlong  [2] = '{0, 0};
    int both   [2] = '{0, 0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign btn_n = ~btn;

    button_debounce #(
        .DEBOUNCE_CYCLES (8), .CNT_W (4), .ACTIVE_LOW (1'b0), .LONG_CYCLES (32), .LONG_W (6)
    ) dut0 (
        .clk (clk), .rst (rst), .btn_raw (btn),
        .btn_level (lvl[0]), .press_pulse (pp[0]), .release_pulse (rp[0]),
        .press_count (pc0), .long_pulse (lp[0])
    );

    button_debounce #(
        .DEBOUNCE_CYCLES (8), .CNT_W (4), .ACTIVE_LOW (1'b1), .LONG_CYCLES (32), .LONG_W (6)
    ) dut1 (
        .clk (clk), .rst (rst), .btn_raw (btn_n),
        .btn_level (lvl[1]), .press_pulse (pp[1]), .release_pulse (rp[1]),
        .press_count (pc1), .long_pulse (lp[1])
    );

    // Pulse log: count and edge stamp of each strobe, sampled mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (pp[i]) begin npress[i] <= npress[i] + 1; tpress[i] <= cyc; end
            if (rp[i]) begin nrel[i] <= nrel[i] + 1; trel[i] <= cyc; end
            if (lp[i]) begin nlong[i] <= nlong[i] + 1; tlong[i] <= cyc; end
            if (pp[i] && rp[i]) both[i] <= 1;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic hold(input logic v, input int n);
        btn = v;
        step(n);
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk2(input string tag, input int o0, input int o1, input int exp);
        chk({tag, "[hi]"}, o0, exp);
        chk({tag, "[lo]"}, o1, exp);
    endtask

    int k, r, j;
    int bp [2];
    int br [2];
    int bl [2];

    task automatic mark();
        for (int i = 0; i < 2; i++) begin
            bp[i] = npress[i];
            br[i] = nrel[i];
            bl[i] = nlong[i];
        end
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        btn = 1'b0;
        step(3);
        chk2("rst_level", lvl[0], lvl[1], 0);
        chk2("rst_count", pc0, pc1, 0);
        chk2("rst_press", pp[0], pp[1], 0);
        chk2("rst_release", rp[0], rp[1], 0);
        chk2("rst_long", lp[0], lp[1], 0);
        rst = 1'b0;
        step(2);

        // Clean press: strobe after edge k+10
        mark();
        k = cyc + 1;
        hold(1'b1, 20);
        chk2("s1_npress", npress[0] - bp[0], npress[1] - bp[1], 1);
        chk2("s1_tpress", tpress[0], tpress[1], k + 10);
        chk2("s1_level", lvl[0], lvl[1], 1);
        chk2("s1_count", pc0, pc1, 1);
        chk2("s1_nrel", nrel[0] - br[0], nrel[1] - br[1], 0);

        // Release glitch rejected, then a real release
        hold(1'b0, 4);
        hold(1'b1, 4);
        chk2("s3_glitch_nrel", nrel[0] - br[0], nrel[1] - br[1], 0);
        chk2("s3_glitch_level", lvl[0], lvl[1], 1);
        r = cyc + 1;
        hold(1'b0, 12);
        chk2("s3_nrel", nrel[0] - br[0], nrel[1] - br[1], 1);
        chk2("s3_trel", trel[0], trel[1], r + 10);
        chk2("s3_level", lvl[0], lvl[1], 0);
        chk2("s3_count", pc0, pc1, 1);
        chk2("s3_nlong", nlong[0] - bl[0], nlong[1] - bl[1], 0);

        // Press bounce rejected
        mark();
        hold(1'b1, 5);
        hold(1'b0, 2);
        k = cyc + 1;
        hold(1'b1, 12);
        chk2("s2_npress", npress[0] - bp[0], npress[1] - bp[1], 1);
        chk2("s2_tpress", tpress[0], tpress[1], k + 10);
        chk2("s2_count", pc0, pc1, 2);
        hold(1'b0, 12);
        chk2("s2_nrel", nrel[0] - br[0], nrel[1] - br[1], 1);

        // Long hold
        mark();
        k = cyc + 1;
        hold(1'b1, 60);
        chk2("s6_npress", npress[0] - bp[0], npress[1] - bp[1], 1);
        chk2("s6_count", pc0, pc1, 3);
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
        chk2("s6_nlong", nlong[0] - bl[0], nlong[1] - bl[1], 1);
        chk2("s6_tlong", tlong[0], tlong[1], k + 10 + 32);
`else
        chk2("s6_nlong", nlong[0] - bl[0], nlong[1] - bl[1], 0);
        chk2("s6_long_now", lp[0], lp[1], 0);
`endif
        hold(1'b0, 12);
        chk2("s6_level", lvl[0], lvl[1], 0);
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
        chk2("s6_nlong_once", nlong[0] - bl[0], nlong[1] - bl[1], 1);
`else
        chk2("s6_nlong_once", nlong[0] - bl[0], nlong[1] - bl[1], 0);
`endif

        // Reset while PRESS_WAIT has cnt = 5
        mark();
        k = cyc + 1;
        btn = 1'b1;
        step(8);
        rst = 1'b1;
        step(1);
        chk2("s5_level", lvl[0], lvl[1], 0);
        chk2("s5_count", pc0, pc1, 0);
        chk2("s5_press", pp[0], pp[1], 0);
        chk2("s5_npress", npress[0] - bp[0], npress[1] - bp[1], 0);
        rst = 1'b0;
        j = cyc + 1;
        step(12);
        chk2("s5_npress_after", npress[0] - bp[0], npress[1] - bp[1], 1);
        chk2("s5_tpress", tpress[0], tpress[1], j + 10);
        chk2("s5_count_after", pc0, pc1, 1);
        chk2("s5_level_after", lvl[0], lvl[1], 1);
        hold(1'b0, 12);

        // Count wrap: 256 presses since reset
        for (int n = 0; n < 254; n++) begin
            hold(1'b1, 12);
            hold(1'b0, 12);
        end
        chk2("s4_count_255", pc0, pc1, 255);
        hold(1'b1, 12);
        hold(1'b0, 12);
        chk2("s4_count_wrap", pc0, pc1, 0);
        chk2("s4_npress", npress[0] - bp[0], npress[1] - bp[1], 256);
        chk2("s4_nrel", nrel[0] - br[0], nrel[1] - br[1], 256);

        chk2("no_overlap", both[0], both[1], 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
